// File: rtl/rf_pkg.sv
// ============================================================================
// rf_pkg : shared defaults for the 2-read / 1-write register file
// Rev 1.0
// ============================================================================
`default_nettype none

package rf_pkg;
  localparam int RF_DATA_W    = 32;
  localparam int RF_ADDR_W    = 5;
  localparam int RF_DEPTH     = 32;
  localparam int RF_ZERO_ADDR = 0;
endpackage

`default_nettype wire

// File: rtl/reg_file_2r1w_if.sv
// ============================================================================
// reg_file_2r1w_if : write, read-request and read-data bundle of the register file
// Rev 1.0
// ============================================================================
`default_nettype none

interface reg_file_2r1w_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              rd_valid;

  modport master (
    output we, waddr, wdata, rd_en, raddr1, raddr2,
    input  rdata1, rdata2, rd_valid
  );

  modport slave (
    input  we, waddr, wdata, rd_en, raddr1, raddr2,
    output rdata1, rdata2, rd_valid
  );
endinterface

`default_nettype wire

// File: rtl/rf_read_port.sv
// ============================================================================
// rf_read_port : DEPTH-way word select with range check, zero register and bypass
// Rev 1.0
// ============================================================================
`default_nettype none

module rf_read_port
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  wire logic [DATA_W-1:0] mem [DEPTH],
  input  wire logic [ADDR_W-1:0] raddr,
  input  wire logic              wr_ok,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  output logic      [DATA_W-1:0] sel
);

  always_comb begin
    sel = '0;
    // Addresses at or beyond DEPTH match no entry and fall through as zero
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) sel = mem[i];
    end
    if ((ZERO_REG != 0) && (raddr == ADDR_W'(RF_ZERO_ADDR))) begin
      sel = '0;
    end else if ((BYPASS != 0) && wr_ok && (waddr == raddr)) begin
      sel = wdata;
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_2r1w.sv
// ============================================================================
// reg_file_2r1w : flip-flop register file, two registered read ports, one write
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_file_2r1w
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int DEPTH    = RF_DEPTH,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input wire logic         clk,
  input wire logic         rst,
  reg_file_2r1w_if.slave   bus
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic              r_rd_valid;
  logic [DATA_W-1:0] w_sel1;
  logic [DATA_W-1:0] w_sel2;
  logic              w_wr_ok;

  // A write counts only when it will actually land; the bypass depends on this too
  assign w_wr_ok = bus.we && ({1'b0, bus.waddr} < c_depth) &&
                   !((ZERO_REG != 0) && (bus.waddr == ADDR_W'(RF_ZERO_ADDR)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_ok && (bus.waddr == ADDR_W'(i))) r_mem[i] <= bus.wdata;
      end
    end
  end

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port1 (
    .mem(r_mem), .raddr(bus.raddr1), .wr_ok(w_wr_ok),
    .waddr(bus.waddr), .wdata(bus.wdata), .sel(w_sel1)
  );

  rf_read_port #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_port2 (
    .mem(r_mem), .raddr(bus.raddr2), .wr_ok(w_wr_ok),
    .waddr(bus.waddr), .wdata(bus.wdata), .sel(w_sel2)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        r_rdata1 <= w_sel1;
        r_rdata2 <= w_sel2;
      end
    end
  end

  assign bus.rdata1   = r_rdata1;
  assign bus.rdata2   = r_rdata2;
  assign bus.rd_valid = r_rd_valid;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_2r1w.sv
// ============================================================================
// tb_reg_file_2r1w : three builds (default, no zero/no bypass, DEPTH=24) vs a model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_2r1w;
  import rf_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        we = 1'b0, rd_en = 1'b0;
  logic [4:0]  waddr = '0, raddr1 = '0, raddr2 = '0;
  logic [31:0] wdata = '0;

  reg_file_2r1w_if bus_a ();
  reg_file_2r1w_if bus_b ();
  reg_file_2r1w_if bus_c ();

  assign bus_a.we = we;  assign bus_a.waddr = waddr;  assign bus_a.wdata = wdata;
  assign bus_a.rd_en = rd_en;  assign bus_a.raddr1 = raddr1;  assign bus_a.raddr2 = raddr2;
  assign bus_b.we = we;  assign bus_b.waddr = waddr;  assign bus_b.wdata = wdata;
  assign bus_b.rd_en = rd_en;  assign bus_b.raddr1 = raddr1;  assign bus_b.raddr2 = raddr2;
  assign bus_c.we = we;  assign bus_c.waddr = waddr;  assign bus_c.wdata = wdata;
  assign bus_c.rd_en = rd_en;  assign bus_c.raddr1 = raddr1;  assign bus_c.raddr2 = raddr2;

  reg_file_2r1w #(.DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  reg_file_2r1w #(.DEPTH(32), .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  reg_file_2r1w #(.DEPTH(24), .ZERO_REG(1), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  logic [31:0] act1 [3];
  logic [31:0] act2 [3];
  logic        actv [3];
  assign act1[0] = bus_a.rdata1;  assign act2[0] = bus_a.rdata2;  assign actv[0] = bus_a.rd_valid;
  assign act1[1] = bus_b.rdata1;  assign act2[1] = bus_b.rdata2;  assign actv[1] = bus_b.rd_valid;
  assign act1[2] = bus_c.rdata1;  assign act2[2] = bus_c.rdata2;  assign actv[2] = bus_c.rd_valid;

  // Reference model: plain per-build arrays and the read-selection rules
  int          cfg_depth [3] = '{32, 32, 24};
  bit          cfg_zero  [3] = '{1'b1, 1'b0, 1'b1};
  bit          cfg_byp   [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mm  [3][32];
  logic [31:0] e1  [3];
  logic [31:0] e2  [3];
  logic        ev  [3];

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  function automatic logic [31:0] model_sel(input int c, input int a);
    int  wa = int'(waddr);
    bit  wlands = we && (wa < cfg_depth[c]) && !(cfg_zero[c] && wa == 0);
    if (a >= cfg_depth[c]) return 32'h0;
    if (cfg_zero[c] && a == 0) return 32'h0;
    if (cfg_byp[c] && wlands && wa == a) return wdata;
    return mm[c][a];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 32; i++) mm[c][i] = '0;
      e1[c] = '0; e2[c] = '0; ev[c] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      int wa = int'(waddr);
      if (rd_en) begin
        e1[c] = model_sel(c, int'(raddr1));
        e2[c] = model_sel(c, int'(raddr2));
      end
      ev[c] = rd_en;
      if (we && wa < cfg_depth[c] && !(cfg_zero[c] && wa == 0)) mm[c][wa] = wdata;
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("%s dut%0d rdata1", tag, c), act1[c], e1[c]);
      chk($sformatf("%s dut%0d rdata2", tag, c), act2[c], e2[c]);
      chk($sformatf("%s dut%0d rd_valid", tag, c), {31'b0, actv[c]}, {31'b0, ev[c]});
    end
  endtask

  // Drive one cycle's inputs, advance past the edge, compare every build with the model
  task automatic cycle(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic r, input logic [4:0] r1, input logic [4:0] r2,
                       input string tag);
    we = w; waddr = wa; wdata = wd; rd_en = r; raddr1 = r1; raddr2 = r2;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rd_en;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] exp1;
    logic [31:0] exp2;
    logic        expv;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Directed vectors, expectations for the default build (ZERO_REG=1, BYPASS=1, DEPTH=32)
    tbl[0]  = '{1'b1, 5'd3,  32'h12345678, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
    tbl[1]  = '{1'b1, 5'd4,  32'hCAFEF00D, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
    tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd4,  32'h12345678, 32'hCAFEF00D, 1'b1};
    tbl[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd9,  5'd9,  32'h12345678, 32'hCAFEF00D, 1'b0};
    tbl[4]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  5'd0,  32'h0,        32'h0,        1'b1};
    tbl[5]  = '{1'b1, 5'd7,  32'hA5A5A5A5, 1'b1, 5'd7,  5'd3,  32'hA5A5A5A5, 32'h12345678, 1'b1};
    tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1};
    tbl[7]  = '{1'b1, 5'd30, 32'h00000001, 1'b1, 5'd30, 5'd31, 32'h00000001, 32'h0,        1'b1};
    tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd30, 5'd0,  32'h00000001, 32'h0,        1'b1};
    tbl[9]  = '{1'b1, 5'd1,  32'h00000011, 1'b0, 5'd0,  5'd0,  32'h00000001, 32'h0,        1'b0};
    tbl[10] = '{1'b1, 5'd2,  32'h00000022, 1'b0, 5'd0,  5'd0,  32'h00000001, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  5'd1,  32'h00000011, 32'h00000011, 1'b1};
    tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  5'd2,  32'h00000022, 32'h00000022, 1'b1};
    tbl[13] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  5'd3,  32'h12345678, 32'h12345678, 1'b1};
    tbl[14] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  5'd4,  32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
    tbl[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  5'd2,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    tbl[16] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  5'd2,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 17; k++) begin
      cycle(tbl[k].we, tbl[k].waddr, tbl[k].wdata, tbl[k].rd_en, tbl[k].raddr1, tbl[k].raddr2,
            $sformatf("vec%0d", k));
      chk($sformatf("vec%0d rdata1", k), act1[0], tbl[k].exp1);
      chk($sformatf("vec%0d rdata2", k), act2[0], tbl[k].exp2);
      chk($sformatf("vec%0d rd_valid", k), {31'b0, actv[0]}, {31'b0, tbl[k].expv});
    end

    // r0 keeps the write only without the zero register; r7 bypass difference settles
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd7, "zero_read");
    chk("zero_reg=1 r0", act1[0], 32'h0);
    chk("zero_reg=0 r0", act1[1], 32'hFFFFFFFF);
    chk("nobypass r7 next read", act2[1], 32'hA5A5A5A5);

    // Same-edge write/read of r7 without bypass returns the old contents
    cycle(1'b1, 5'd7, 32'h5A5A5A5A, 1'b1, 5'd7, 5'd7, "bypass_edge");
    chk("bypass=1 same edge", act1[0], 32'h5A5A5A5A);
    chk("bypass=0 same edge", act1[1], 32'hA5A5A5A5);

    // DEPTH=24: write beyond range ignored, full sweep of r0..r23 against the model
    cycle(1'b1, 5'd30, 32'h00000001, 1'b1, 5'd30, 5'd30, "range_wr");
    chk("depth24 r30", act1[2], 32'h0);
    for (int a = 0; a < 24; a += 2)
      cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 5'(a + 1), $sformatf("sweep%0d", a));

    // Randomised traffic across all three builds
    for (int n = 0; n < 300; n++)
      cycle(1'($urandom), 5'($urandom), $urandom, 1'($urandom), 5'($urandom), 5'($urandom),
            $sformatf("rand%0d", n));

    // Asynchronous reset in mid-cycle: outputs clear without an edge, storage clears too
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd7, 5'd3, "pre_reset");
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd5, "pre_reset_rd");
    chk("r5 before reset", act1[0], 32'hDEADBEEF);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    we = 1'b1; waddr = 5'd6; wdata = 32'h13579BDF; rd_en = 1'b1;
    @(posedge clk);
    #1;
    check_all("in_reset");
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6, "post_reset");
    chk("r5 after reset", act1[0], 32'h0);
    chk("r6 write during reset", act2[0], 32'h0);
    chk("rd_valid after reset read", {31'b0, actv[0]}, 32'h1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
